// File: rtl/mul8_seq_ctrl_pkg.sv
// mul8_seq_ctrl_pkg: shared types and constants for the 8x8 nibble-sequenced multiplier controller.
package mul8_seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DRAIN, DONE} state_e;
  localparam int STEP_W = 2;
  localparam int OP_W = 8;
  localparam int RES_W = 16;
  localparam int NIB_W = 4;
  localparam int SH_W = 4;
  localparam logic [SH_W-1:0] SHIFT_0 = 4'd0;
  localparam logic [SH_W-1:0] SHIFT_1 = 4'd4;
  localparam logic [SH_W-1:0] SHIFT_2 = 4'd4;
  localparam logic [SH_W-1:0] SHIFT_3 = 4'd8;
  function automatic logic [SH_W-1:0] step_shift(input logic [STEP_W-1:0] s);
    return s == 2'd0 ? SHIFT_0 : s == 2'd1 ? SHIFT_1 : s == 2'd2 ? SHIFT_2 : SHIFT_3;
  endfunction
endpackage

// File: rtl/mul8_nib_sel.sv
// mul8_nib_sel: maps a step index to the nibble pair and accumulation shift for that step.
module mul8_nib_sel
  import mul8_seq_ctrl_pkg::*;
(
  input  logic [STEP_W-1:0] step_i,
  input  logic [OP_W-1:0]   x_i,
  input  logic [OP_W-1:0]   y_i,
  output logic [NIB_W-1:0]  x_o,
  output logic [NIB_W-1:0]  y_o,
  output logic [SH_W-1:0]   shift_o
);
  // step bit 1 selects the high x nibble, bit 0 the high y nibble
  assign x_o = step_i[1] ? x_i[7:4] : x_i[3:0];
  assign y_o = step_i[0] ? y_i[7:4] : y_i[3:0];
  assign shift_o = step_shift(step_i);
endmodule

// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: 8x8->16 unsigned multiply by time-sharing an external 4x4 multiplier over four steps.
module mul8_seq_ctrl
  import mul8_seq_ctrl_pkg::*;
#(
  parameter bit PIPE = 1'b0,
  parameter int NIB  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_x,
  input  logic [OP_W-1:0]   in_y,
  input  logic              flush,
  output logic [NIB_W-1:0]  mul_x,
  output logic [NIB_W-1:0]  mul_y,
  input  logic [2*NIB_W-1:0] mul_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_p,
  output logic              busy
);
  if (NIB != 4) begin : g_nib_chk
    $error("mul8_seq_ctrl: NIB must be 4");
  end
  state_e state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [OP_W-1:0] x_q, y_q;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [2*NIB_W-1:0] mul_q;
  logic [SH_W-1:0] sh_q, sh;
  logic pv_q;
  logic [NIB_W-1:0] nx, ny;
  logic active, accept;
  logic [RES_W-1:0] add_now, add_pipe;
  mul8_nib_sel u_sel (
    .step_i (step_q),
    .x_i    (x_q),
    .y_i    (y_q),
    .x_o    (nx),
    .y_o    (ny),
    .shift_o(sh)
  );
  assign active = state_q == MUL;
  assign accept = state_q == IDLE && in_valid && !flush;
  assign add_now = RES_W'(mul_o) << sh;
  // pipelined path accumulates the product registered during the previous step
  assign add_pipe = pv_q ? RES_W'(mul_q) << sh_q : '0;
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    acc_d = acc_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = MUL;
        step_d = '0;
        acc_d = '0;
      end
      MUL: begin
        step_d = step_q + 1'b1;
        acc_d = acc_q + (PIPE ? add_pipe : add_now);
        if (step_q == STEP_W'(3)) state_d = PIPE ? DRAIN : DONE;
      end
      DRAIN: begin
        acc_d = acc_q + add_pipe;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      step_d = '0;
      acc_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q <= '0;
      acc_q <= '0;
      x_q <= '0;
      y_q <= '0;
      mul_q <= '0;
      sh_q <= '0;
      pv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      acc_q <= acc_d;
      if (accept) begin
        x_q <= in_x;
        y_q <= in_y;
      end
      mul_q <= active ? mul_o : '0;
      sh_q <= sh;
      pv_q <= active && !flush;
    end
  end
  assign mul_x = active ? nx : '0;
  assign mul_y = active ? ny : '0;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_p = out_valid ? acc_q : '0;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb_mul8_seq_ctrl: table-driven and directed checks of both PIPE variants against hand-computed products.
module tb_mul8_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid [2], in_ready [2], flush [2], out_valid [2], out_ready [2], busy [2];
  logic [7:0] in_x [2], in_y [2], mul_o [2];
  logic [3:0] mul_x [2], mul_y [2];
  logic [15:0] out_p [2];
  int pass_cnt = 0;
  int total_cnt = 0;
  mul8_seq_ctrl #(.PIPE(1'b0), .NIB(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_x(in_x[0]), .in_y(in_y[0]), .flush(flush[0]), .mul_x(mul_x[0]), .mul_y(mul_y[0]),
    .mul_o(mul_o[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_p(out_p[0]),
    .busy(busy[0])
  );
  mul8_seq_ctrl #(.PIPE(1'b1), .NIB(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_x(in_x[1]), .in_y(in_y[1]), .flush(flush[1]), .mul_x(mul_x[1]), .mul_y(mul_y[1]),
    .mul_o(mul_o[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_p(out_p[1]),
    .busy(busy[1])
  );
  // stand-in for the shared 4x4 array multiplier
  assign mul_o[0] = 8'(mul_x[0]) * 8'(mul_y[0]);
  assign mul_o[1] = 8'(mul_x[1]) * 8'(mul_y[1]);
  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] p;
  } vec_t;
  vec_t vecs [10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask
  task automatic run_op(input int d, input logic [7:0] x, input logic [7:0] y, output int lat,
                        output logic [15:0] p, output logic [31:0] seq, output logic [7:0] q5);
    lat = -1;
    p = '0;
    seq = '0;
    q5 = 8'hEE;
    @(negedge clk);
    in_valid[d] = 1'b1;
    in_x[d] = x;
    in_y[d] = y;
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_x[d] = ~x;
    in_y[d] = ~y;
    for (int n = 1; n < 20; n++) begin
      if (n <= 4) seq[(4-n)*8 +: 8] = {mul_x[d], mul_y[d]};
      if (n == 5) q5 = {mul_x[d], mul_y[d]};
      if (out_valid[d]) begin
        lat = n;
        p = out_p[d];
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic watch_idle(input int d, input int cycles, input string name);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen = seen | out_valid[d] | busy[d];
    end
    chk(name, {31'b0, seen}, 32'd0);
  endtask
  task automatic rand_sweep(input int d, input int n_ops);
    logic [15:0] q [$];
    int acc_n = 0;
    int res_n = 0;
    int cyc = 0;
    logic [7:0] x, y;
    while (res_n < n_ops && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      x = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      in_valid[d] = acc_n < n_ops && $urandom_range(0, 1) == 1;
      in_x[d] = x;
      in_y[d] = y;
      out_ready[d] = $urandom_range(0, 3) != 0;
      if (in_valid[d] && in_ready[d]) begin
        q.push_back(16'(x) * 16'(y));
        acc_n++;
      end
      if (out_valid[d] && out_ready[d]) begin
        if (q.size() == 0) chk("rand_extra", 32'(out_p[d]), 32'hFFFF_FFFF);
        else chk("rand_p", 32'(out_p[d]), 32'(q.pop_front()));
        res_n++;
      end
    end
    @(negedge clk);
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    chk("rand_count", res_n, acc_n);
    chk("rand_total", res_n, n_ops);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end
  initial begin
    int lat;
    logic [15:0] p;
    logic [31:0] seq;
    logic [7:0] q5;
    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{8'h12, 8'h34, 16'h03A8};
    vecs[2] = '{8'h00, 8'h37, 16'h0000};
    vecs[3] = '{8'h9C, 8'h00, 16'h0000};
    vecs[4] = '{8'h01, 8'h01, 16'h0001};
    vecs[5] = '{8'h10, 8'h10, 16'h0100};
    vecs[6] = '{8'h0F, 8'hF0, 16'h0E10};
    vecs[7] = '{8'h7B, 8'h2D, 16'h159F};
    vecs[8] = '{8'h55, 8'hAA, 16'h3872};
    vecs[9] = '{8'hFF, 8'h01, 16'h00FF};
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      flush[d] = 1'b0;
      out_ready[d] = 1'b0;
      in_x[d] = '0;
      in_y[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk("reset_out", {5'b0, in_ready[d], out_valid[d], out_p[d], mul_x[d], mul_y[d], busy[d]},
          {5'b0, 1'b1, 26'b0});
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) out_ready[d] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 10; i++) begin
        run_op(d, vecs[i].x, vecs[i].y, lat, p, seq, q5);
        chk("vec_latency", lat, 5 + d);
        chk("vec_product", 32'(p), 32'(vecs[i].p));
        chk("vec_nibbles", seq, {vecs[i].x[3:0], vecs[i].y[3:0], vecs[i].x[3:0], vecs[i].y[7:4],
                                 vecs[i].x[7:4], vecs[i].y[3:0], vecs[i].x[7:4], vecs[i].y[7:4]});
        chk("vec_quiet_after_step3", 32'(q5), 32'd0);
        @(negedge clk);
        chk("vec_idle_after", {30'b0, busy[d], in_ready[d]}, 32'd1);
      end
    end
    for (int d = 0; d < 2; d++) begin
      out_ready[d] = 1'b0;
      run_op(d, 8'hC3, 8'h3C, lat, p, seq, q5);
      chk("bp_latency", lat, 5 + d);
      in_valid[d] = 1'b1;
      in_x[d] = 8'h11;
      in_y[d] = 8'h11;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk("bp_hold", {14'b0, out_valid[d], in_ready[d], out_p[d]}, {14'b0, 2'b10, 16'h2DB4});
      end
      out_ready[d] = 1'b1;
      in_valid[d] = 1'b0;
      @(negedge clk);
      chk("bp_release", {30'b0, in_ready[d], out_valid[d]}, 32'd2);
      watch_idle(d, 8, "bp_no_stale_accept");
    end
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      in_valid[d] = 1'b1;
      in_x[d] = 8'hA5;
      in_y[d] = 8'h5A;
      @(negedge clk);
      in_valid[d] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      flush[d] = 1'b1;
      @(negedge clk);
      flush[d] = 1'b0;
      chk("flush_mul", {26'b0, busy[d], out_valid[d], mul_x[d]}, 32'd0);
      watch_idle(d, 8, "flush_mul_no_result");
      run_op(d, 8'h03, 8'h07, lat, p, seq, q5);
      chk("flush_next_product", 32'(p), 32'h0015);
      chk("flush_next_latency", lat, 5 + d);
      @(negedge clk);
      in_valid[d] = 1'b1;
      in_x[d] = 8'hFF;
      in_y[d] = 8'hFF;
      flush[d] = 1'b1;
      @(negedge clk);
      in_valid[d] = 1'b0;
      flush[d] = 1'b0;
      chk("flush_idle_accept", {30'b0, busy[d], in_ready[d]}, 32'd1);
      watch_idle(d, 6, "flush_idle_no_result");
      out_ready[d] = 1'b0;
      run_op(d, 8'h05, 8'h06, lat, p, seq, q5);
      chk("flush_done_product", 32'(p), 32'h001E);
      flush[d] = 1'b1;
      out_ready[d] = 1'b1;
      @(negedge clk);
      flush[d] = 1'b0;
      chk("flush_done_idle", {30'b0, out_valid[d], in_ready[d]}, 32'd1);
    end
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      in_valid[d] = 1'b1;
      in_x[d] = 8'h77;
      in_y[d] = 8'h88;
      @(negedge clk);
      in_valid[d] = 1'b0;
      @(negedge clk);
      chk("rst_pre_busy", {31'b0, busy[d]}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", {5'b0, in_ready[d], out_valid[d], out_p[d], mul_x[d], mul_y[d], busy[d]},
             {5'b0, 1'b1, 26'b0});
      @(negedge clk);
      rst_n = 1'b1;
      watch_idle(d, 8, "rst_no_result");
      chk("rst_in_ready", {31'b0, in_ready[d]}, 32'd1);
    end
    rand_sweep(0, 200);
    rand_sweep(1, 200);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
